mips_bus_monitor: RTL and testbench

Synthesisable run-supervisor and Avalon protocol checker for the `mips_cpu_bus` master port. It sits passively in parallel with the CPU-to-memory bus inside the CPU bus testbench and FPGA wrapper. It replaces ad-hoc bench cycle counting with parametrised, registered hardware: run/drain/done/timeout sequencing, transfer and stall statistics, and sticky protocol-error flags.

---
 rtl/mips_bus_monitor_pkg.sv | 18 +
 rtl/mips_bus_hold_checker.sv | 50 +++++
 rtl/mips_bus_monitor.sv | 130 +++++++++++++
 tb/tb_mips_bus_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_monitor_pkg.sv
// Shared types and constants for the mips_cpu_bus run supervisor and protocol checker.
package mips_bus_monitor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_DONE    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam int unsigned ERR_W     = 4;
   localparam int unsigned ERR_RW    = 0;
   localparam int unsigned ERR_HOLD  = 1;
   localparam int unsigned ERR_BE    = 2;
   localparam int unsigned ERR_ALIGN = 3;

endpackage

// File: rtl/mips_bus_hold_checker.sv
// Flags a change of request signals while the slave holds waitrequest.
module mips_bus_hold_checker (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [3:0]  byteenable,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        waitrequest,
   output logic        hold_viol_c
);

   logic        snap_vld;
   logic [31:0] snap_addr;
   logic [3:0]  snap_be;
   logic        snap_rd;
   logic        snap_wr;
   logic [31:0] snap_wd;

   // One-cycle snapshot of the bus, valid only after a stalled request
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_vld  <= 1'b0;
         snap_addr <= 32'd0;
         snap_be   <= 4'd0;
         snap_rd   <= 1'b0;
         snap_wr   <= 1'b0;
         snap_wd   <= 32'd0;
      end else begin
         snap_vld  <= (read | write) & waitrequest;
         snap_addr <= address;
         snap_be   <= byteenable;
         snap_rd   <= read;
         snap_wr   <= write;
         snap_wd   <= writedata;
      end
   end

   // Compare current bus against snapshot; writedata only matters for a held write
   always_comb begin
      hold_viol_c = 1'b0;
      if (snap_vld) begin
         hold_viol_c = (address != snap_addr) || (byteenable != snap_be) ||
                       (read != snap_rd) || (write != snap_wr) ||
                       (snap_wr && (writedata != snap_wd));
      end
   end

endmodule

// File: rtl/mips_bus_monitor.sv
// Passive run supervisor, transfer statistics and Avalon protocol checker for mips_cpu_bus.
module mips_bus_monitor
   import mips_bus_monitor_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 10000,
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned CHECK_ALIGN    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_active,
   input  logic             wb_empty,
   input  logic [31:0]      address,
   input  logic [3:0]       byteenable,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   input  logic             waitrequest,
   output logic [2:0]       state,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] rd_count,
   output logic [CNT_W-1:0] wr_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [3:0]       err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   // Wide compare so a budget beyond the counter range is simply never reached
   localparam int unsigned CMP_W = CNT_W + 32;

   state_t          state_q;
   state_t          state_d;
   logic            live_c;
   logic            req_c;
   logic            cyc_en_c;
   logic            budget_hit_c;
   logic            hold_viol_c;
   logic [ERR_W-1:0] err_new_c;

   mips_bus_hold_checker u_hold (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .byteenable  (byteenable),
      .read        (read),
      .write       (write),
      .writedata   (writedata),
      .waitrequest (waitrequest),
      .hold_viol_c (hold_viol_c)
   );

   assign state = 3'(state_q);

   // Qualifiers shared by the FSM, counters and checks
   always_comb begin
      live_c       = (state_q != ST_DONE) && (state_q != ST_TIMEOUT);
      req_c        = read | write;
      cyc_en_c     = live_c && cpu_active;
      budget_hit_c = cyc_en_c && (CMP_W'(cycles) == CMP_W'(TIMEOUT_CYCLES));
   end

   // Supervisor state register
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; budget expiry overrides every other transition
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cpu_active) state_d = ST_RUN;
         ST_RUN:   if (!cpu_active) state_d = wb_empty ? ST_DONE : ST_DRAIN;
         ST_DRAIN: begin
            if (cpu_active)    state_d = ST_RUN;
            else if (wb_empty) state_d = ST_DONE;
         end
         default:  state_d = state_q;
      endcase
      if (budget_hit_c) state_d = ST_TIMEOUT;
   end

   // Sticky completion flags track entry into the terminal states
   always_ff @(posedge clk) begin
      if (reset) begin
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         if (state_d == ST_DONE)    done    <= 1'b1;
         if (state_d == ST_TIMEOUT) timeout <= 1'b1;
      end
   end

   // Saturating statistics counters, frozen once a terminal state is reached
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles      <= '0;
         rd_count    <= '0;
         wr_count    <= '0;
         stall_count <= '0;
      end else if (live_c) begin
         if (cyc_en_c && (cycles != CNT_MAX))
            cycles <= cycles + CNT_W'(1);
         if (read && !waitrequest && (rd_count != CNT_MAX))
            rd_count <= rd_count + CNT_W'(1);
         if (write && !waitrequest && (wr_count != CNT_MAX))
            wr_count <= wr_count + CNT_W'(1);
         if (req_c && waitrequest && (stall_count != CNT_MAX))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

   // Per-cycle protocol violations
   always_comb begin
      err_new_c            = '0;
      err_new_c[ERR_RW]    = read & write;
      err_new_c[ERR_HOLD]  = hold_viol_c;
      err_new_c[ERR_BE]    = req_c && (byteenable == 4'd0);
      err_new_c[ERR_ALIGN] = (CHECK_ALIGN != 0) && req_c && (address[1:0] != 2'd0);
   end

   // Sticky error flags, only accumulated outside terminal states
   always_ff @(posedge clk) begin
      if (reset)       err <= '0;
      else if (live_c) err <= err | err_new_c;
   end

endmodule

// File: tb/tb_mips_bus_monitor.sv
// Directed self-checking bench for mips_bus_monitor.
module tb_mips_bus_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_active;
   logic        wb_empty;
   logic [31:0] address;
   logic [3:0]  byteenable;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic        waitrequest;

   // default-parameter instance
   logic [2:0]  d_state;
   logic        d_done, d_timeout;
   logic [31:0] d_cycles, d_rd, d_wr, d_stall;
   logic [3:0]  d_err;
   // small budget instance
   logic [2:0]  t_state;
   logic        t_done, t_timeout;
   logic [31:0] t_cycles, t_rd, t_wr, t_stall;
   logic [3:0]  t_err;
   // narrow counters, alignment check disabled
   logic [2:0]  s_state;
   logic        s_done, s_timeout;
   logic [2:0]  s_cycles, s_rd, s_wr, s_stall;
   logic [3:0]  s_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_bus_monitor dut (
      .clk(clk), .reset(reset), .cpu_active(cpu_active), .wb_empty(wb_empty),
      .address(address), .byteenable(byteenable), .read(read), .write(write),
      .writedata(writedata), .waitrequest(waitrequest),
      .state(d_state), .done(d_done), .timeout(d_timeout), .cycles(d_cycles),
      .rd_count(d_rd), .wr_count(d_wr), .stall_count(d_stall), .err(d_err));

   mips_bus_monitor #(.TIMEOUT_CYCLES(8)) dut_to (
      .clk(clk), .reset(reset), .cpu_active(cpu_active), .wb_empty(wb_empty),
      .address(address), .byteenable(byteenable), .read(read), .write(write),
      .writedata(writedata), .waitrequest(waitrequest),
      .state(t_state), .done(t_done), .timeout(t_timeout), .cycles(t_cycles),
      .rd_count(t_rd), .wr_count(t_wr), .stall_count(t_stall), .err(t_err));

   mips_bus_monitor #(.TIMEOUT_CYCLES(100), .CNT_W(3), .CHECK_ALIGN(0)) dut_sat (
      .clk(clk), .reset(reset), .cpu_active(cpu_active), .wb_empty(wb_empty),
      .address(address), .byteenable(byteenable), .read(read), .write(write),
      .writedata(writedata), .waitrequest(waitrequest),
      .state(s_state), .done(s_done), .timeout(s_timeout), .cycles(s_cycles),
      .rd_count(s_rd), .wr_count(s_wr), .stall_count(s_stall), .err(s_err));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      read = 1'b0; write = 1'b0; address = 32'd0; byteenable = 4'd0;
      writedata = 32'd0; waitrequest = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; cpu_active = 1'b0; wb_empty = 1'b0;
      bus_idle();
      tick();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},   64'(d_state),   64'd0);
      check({tag, "_done"},    64'(d_done),    64'd0);
      check({tag, "_timeout"}, 64'(d_timeout), 64'd0);
      check({tag, "_cycles"},  64'(d_cycles),  64'd0);
      check({tag, "_rd"},      64'(d_rd),      64'd0);
      check({tag, "_wr"},      64'(d_wr),      64'd0);
      check({tag, "_stall"},   64'(d_stall),   64'd0);
      check({tag, "_err"},     64'(d_err),     64'd0);
   endtask

   initial begin
      // reset state
      do_reset();
      tick();
      check_reset_vals("rst");

      // stalled read, writedata wiggles (ignored for reads), then accepted; then one write
      read = 1'b1; address = 32'h1000; byteenable = 4'hF; waitrequest = 1'b1;
      tick();
      writedata = 32'h55;
      tick();
      tick();
      waitrequest = 1'b0;
      tick();
      bus_idle();
      write = 1'b1; address = 32'h2000; writedata = 32'hDEAD; byteenable = 4'hF;
      tick();
      bus_idle();
      tick();
      check("stall_cnt", 64'(d_stall), 64'd3);
      check("rd_cnt", 64'(d_rd), 64'd1);
      check("wr_cnt", 64'(d_wr), 64'd1);
      check("stall_err", 64'(d_err), 64'd0);
      check("idle_state", 64'(d_state), 64'd0);
      check("idle_cycles", 64'(d_cycles), 64'd0);

      // 20 active cycles; small-budget instance times out on the 9th
      cpu_active = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 1) check("run_state", 64'(d_state), 64'd1);
         if (i == 8) begin
            check("to_cyc8", 64'(t_cycles), 64'd8);
            check("to_not_yet", 64'(t_timeout), 64'd0);
         end
         if (i == 9) begin
            check("to_flag", 64'(t_timeout), 64'd1);
            check("to_state", 64'(t_state), 64'd4);
         end
      end
      check("run20_cycles", 64'(d_cycles), 64'd20);
      check("run20_done", 64'(d_done), 64'd0);
      check("sat_cycles", 64'(s_cycles), 64'd7);
      cpu_active = 1'b0; wb_empty = 1'b1;
      tick();
      check("done_flag", 64'(d_done), 64'd1);
      check("done_state", 64'(d_state), 64'd3);
      check("done_cycles", 64'(d_cycles), 64'd20);
      check("to_frozen", 64'(t_cycles), 64'd9);
      check("to_state_kept", 64'(t_state), 64'd4);
      check("to_no_done", 64'(t_done), 64'd0);
      // terminal state freezes counters and checks
      read = 1'b1; write = 1'b1; address = 32'h3; byteenable = 4'd0;
      tick();
      bus_idle();
      tick();
      check("frozen_rd", 64'(d_rd), 64'd1);
      check("frozen_err", 64'(d_err), 64'd0);

      // address change while stalled, flag persists after bus idles
      do_reset();
      read = 1'b1; address = 32'h1000; byteenable = 4'hF; waitrequest = 1'b1;
      tick();
      address = 32'h1004;
      tick();
      check("hold_err", 64'(d_err), 64'b0010);
      bus_idle();
      tick();
      tick();
      check("hold_sticky", 64'(d_err), 64'b0010);

      // RW + BE + ALIGN in one cycle
      do_reset();
      read = 1'b1; write = 1'b1; byteenable = 4'd0; address = 32'h1002;
      tick();
      bus_idle();
      check("multi_err", 64'(d_err), 64'b1101);
      check("multi_rd", 64'(d_rd), 64'd1);
      check("multi_wr", 64'(d_wr), 64'd1);
      check("noalign_err", 64'(s_err), 64'b0101);

      // RW and HOLD together
      do_reset();
      read = 1'b1; address = 32'h1000; byteenable = 4'hF; waitrequest = 1'b1;
      tick();
      write = 1'b1;
      tick();
      bus_idle();
      check("rw_hold_err", 64'(d_err), 64'b0011);

      // writedata change on a held write
      do_reset();
      write = 1'b1; address = 32'h3000; byteenable = 4'hF; writedata = 32'h11; waitrequest = 1'b1;
      tick();
      writedata = 32'h22;
      tick();
      bus_idle();
      check("wd_hold_err", 64'(d_err), 64'b0010);

      // drain for 4 cycles then done
      do_reset();
      cpu_active = 1'b1;
      tick(); tick(); tick();
      cpu_active = 1'b0; wb_empty = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("drain_%0d", i), 64'(d_state), 64'd2);
      end
      wb_empty = 1'b1;
      tick();
      check("drain_done_state", 64'(d_state), 64'd3);
      check("drain_done_flag", 64'(d_done), 64'd1);
      check("drain_cycles", 64'(d_cycles), 64'd3);

      // drain, reassert, drain again, error, then reset mid-drain
      do_reset();
      cpu_active = 1'b1;
      tick(); tick();
      cpu_active = 1'b0; wb_empty = 1'b0;
      tick(); tick();
      cpu_active = 1'b1;
      tick();
      check("reassert_state", 64'(d_state), 64'd1);
      check("reassert_cycles", 64'(d_cycles), 64'd3);
      cpu_active = 1'b0;
      tick();
      check("redrain_state", 64'(d_state), 64'd2);
      read = 1'b1; write = 1'b1; byteenable = 4'hF; address = 32'h0;
      tick();
      check("drain_rw_err", 64'(d_err), 64'b0001);
      do_reset();
      check_reset_vals("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
